// File: rtl/r_ordering_unit_if.sv
// R-channel beat bundle shared between the response buffer, the reorder unit and the master.
interface r_if #(
    parameter int ID_WIDTH   = 32,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2
);
    logic                  valid;
    logic                  ready;
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [RESP_WIDTH-1:0] resp;
    logic                  last;

    modport sender   (output valid, id, data, resp, last, input  ready);
    modport receiver (input  valid, id, data, resp, last, output ready);
endinterface

// File: rtl/r_ordering_unit.sv
// Reorders tagged single-beat R responses back into AR allocation order.
module r_ordering_unit #(
    parameter int  ID_WIDTH   = 32,
    parameter int  DATA_WIDTH = 64,
    parameter int  RESP_WIDTH = 2,
    parameter int  DEPTH      = 8,
    localparam int TAG_W      = $clog2(DEPTH),
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    output logic             alloc_ready,
    input  logic [ID_WIDTH-1:0] alloc_orig_id,
    output logic [TAG_W-1:0] alloc_tag,
    r_if.receiver            r_in,
    r_if.sender              r_out,
    output logic [CNT_W-1:0] count,
    output logic             err_unexpected
);
    // Bit 0 marks PENDING, bit 1 marks FILLED, so tests need only single-bit logic.
    localparam logic [1:0] ST_FREE   = 2'b00;
    localparam logic [1:0] ST_PEND   = 2'b01;
    localparam logic [1:0] ST_FILLED = 2'b10;

    logic [1:0]            st        [DEPTH];
    logic [ID_WIDTH-1:0]   orig_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem  [DEPTH];
    logic [RESP_WIDTH-1:0] resp_mem  [DEPTH];
    logic                  last_mem  [DEPTH];

    logic [TAG_W-1:0] hd;
    logic [TAG_W-1:0] tl;
    logic [TAG_W-1:0] in_tag;
    logic [CNT_W-1:0] cnt;
    logic             err;
    logic             in_upper;
    logic             alloc_fire;
    logic             fill;
    logic             head_filled;
    logic             retire;

    assign in_tag      = r_in.id[TAG_W-1:0];
    assign in_upper    = |r_in.id[ID_WIDTH-1:TAG_W];
    assign alloc_ready = ~st[tl][0] & ~st[tl][1];
    assign alloc_tag   = tl;
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign fill        = r_in.valid & ~in_upper & st[in_tag][0] & ~st[in_tag][1];
    assign head_filled = st[hd][1];
    assign retire      = head_filled & r_out.ready;

    assign r_in.ready  = 1'b1;

    // Head slot is presented straight from storage; payload is masked when not FILLED.
    assign r_out.valid = head_filled;
    assign r_out.id    = {ID_WIDTH{head_filled}} & orig_mem[hd];
    assign r_out.data  = {DATA_WIDTH{head_filled}} & data_mem[hd];
    assign r_out.resp  = {RESP_WIDTH{head_filled}} & resp_mem[hd];
    assign r_out.last  = head_filled & last_mem[hd];

    assign count          = cnt;
    assign err_unexpected = err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) st[i] <= ST_FREE;
            hd  <= '0;
            tl  <= '0;
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (alloc_fire) begin
                st[tl] <= ST_PEND;
                tl     <= tl + 1'b1;
            end
            if (fill) st[in_tag] <= ST_FILLED;
            if (retire) begin
                st[hd] <= ST_FREE;
                hd     <= hd + 1'b1;
            end
            cnt <= cnt + CNT_W'(alloc_fire) - CNT_W'(retire);
            err <= r_in.valid & ~fill;
        end
    end

    // Payload storage carries no reset; validity is tracked solely by st.
    always_ff @(posedge clk) begin
        if (alloc_fire) orig_mem[tl] <= alloc_orig_id;
        if (fill) begin
            data_mem[in_tag] <= r_in.data;
            resp_mem[in_tag] <= r_in.resp;
            last_mem[in_tag] <= r_in.last;
        end
    end
endmodule

// File: tb/tb_r_ordering_unit.sv
// Directed bench for r_ordering_unit: vector table plus hand-written multi-cycle sequences.
module tb_r_ordering_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alloc_valid = 1'b0;
    logic        alloc_ready;
    logic [31:0] alloc_orig_id = '0;
    logic [2:0]  alloc_tag;
    logic [3:0]  count;
    logic        err_unexpected;

    int checks = 0;
    int errors = 0;

    r_if #(.ID_WIDTH(32), .DATA_WIDTH(64), .RESP_WIDTH(2)) rin ();
    r_if #(.ID_WIDTH(32), .DATA_WIDTH(64), .RESP_WIDTH(2)) rout ();

    r_ordering_unit dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_valid    (alloc_valid),
        .alloc_ready    (alloc_ready),
        .alloc_orig_id  (alloc_orig_id),
        .alloc_tag      (alloc_tag),
        .r_in           (rin.receiver),
        .r_out          (rout.sender),
        .count          (count),
        .err_unexpected (err_unexpected)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [31:0] oid;
        logic        rv;
        logic [31:0] rid;
        logic [63:0] rd;
        logic        rdy;
        logic        e_ar;
        logic [2:0]  e_tag;
        logic        e_ov;
        logic [31:0] e_id;
        logic [63:0] e_data;
        logic [3:0]  e_cnt;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic av, logic [31:0] oid, logic rv, logic [31:0] rid,
                                logic [63:0] rd, logic rdy, logic ear, logic [2:0] etag,
                                logic eov, logic [31:0] eid, logic [63:0] ed, logic [3:0] ecnt,
                                logic eerr);
        vec_t v;
        v.rst = r; v.av = av; v.oid = oid; v.rv = rv; v.rid = rid; v.rd = rd; v.rdy = rdy;
        v.e_ar = ear; v.e_tag = etag; v.e_ov = eov; v.e_id = eid; v.e_data = ed;
        v.e_cnt = ecnt; v.e_err = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic av, input logic [31:0] oid, input logic rv,
                          input logic [31:0] rid, input logic [63:0] rd, input logic rdy);
        alloc_valid   = av;
        alloc_orig_id = oid;
        rin.valid     = rv;
        rin.id        = rid;
        rin.data      = rd;
        rin.resp      = rd[1:0];
        rin.last      = rd[0];
        rout.ready    = rdy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 1);

        // rst av oid rv rid data rdy | ar tag ov id data cnt err
        tbl.push_back(mk(1,0,0,    0,0,0,      1, 1,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,'h11, 0,0,0,      1, 1,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,'h22, 1,0,'hAAAA, 1, 1,1,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,    1,1,'hBBBB, 1, 1,2,1,'h11,'hAAAA,2,0));
        tbl.push_back(mk(0,0,0,    0,0,0,      1, 1,2,1,'h22,'hBBBB,1,0));
        tbl.push_back(mk(0,0,0,    0,0,0,      1, 1,2,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,    0,0,0,      1, 1,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,'hA,  0,0,0,      1, 1,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,'hB,  0,0,0,      1, 1,1,0,0,0,1,0));
        tbl.push_back(mk(0,1,'hC,  0,0,0,      1, 1,2,0,0,0,2,0));
        tbl.push_back(mk(0,0,0,    1,2,3,      1, 1,3,0,0,0,3,0));
        tbl.push_back(mk(0,0,0,    1,0,1,      1, 1,3,0,0,0,3,0));
        tbl.push_back(mk(0,0,0,    1,1,2,      1, 1,3,1,'hA,1,3,0));
        tbl.push_back(mk(0,0,0,    0,0,0,      1, 1,3,1,'hB,2,2,0));
        tbl.push_back(mk(0,0,0,    0,0,0,      1, 1,3,1,'hC,3,1,0));
        tbl.push_back(mk(0,0,0,    0,0,0,      1, 1,3,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,    0,0,0,      1, 1,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,'h33, 0,0,0,      0, 1,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,    1,0,'h55,   0, 1,1,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,    1,3,'h77,   0, 1,1,1,'h33,'h55,1,0));
        tbl.push_back(mk(0,0,0,    1,0,'h99,   0, 1,1,1,'h33,'h55,1,1));
        tbl.push_back(mk(0,0,0,    1,'h100,'h88,0,1,1,1,'h33,'h55,1,1));
        tbl.push_back(mk(0,0,0,    0,0,0,      0, 1,1,1,'h33,'h55,1,1));
        tbl.push_back(mk(0,0,0,    0,0,0,      1, 1,1,1,'h33,'h55,1,0));
        tbl.push_back(mk(0,0,0,    0,0,0,      1, 1,1,0,0,0,0,0));
        tbl.push_back(mk(0,1,'h44, 1,1,'h66,   1, 1,1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,    0,0,0,      1, 1,2,0,0,0,1,1));

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            @(negedge clk);
            rst = v.rst;
            set_in(v.av, v.oid, v.rv, v.rid, v.rd, v.rdy);
            #1;
            chk($sformatf("v%0d alloc_ready", i), 64'(alloc_ready), 64'(v.e_ar));
            chk($sformatf("v%0d alloc_tag", i), 64'(alloc_tag), 64'(v.e_tag));
            chk($sformatf("v%0d out_valid", i), 64'(rout.valid), 64'(v.e_ov));
            chk($sformatf("v%0d out_id", i), 64'(rout.id), 64'(v.e_id));
            chk($sformatf("v%0d out_data", i), rout.data, v.e_data);
            chk($sformatf("v%0d out_resp", i), 64'(rout.resp), v.e_ov ? 64'(v.e_data[1:0]) : 64'd0);
            chk($sformatf("v%0d out_last", i), 64'(rout.last), v.e_ov ? 64'(v.e_data[0]) : 64'd0);
            chk($sformatf("v%0d count", i), 64'(count), 64'(v.e_cnt));
            chk($sformatf("v%0d err", i), 64'(err_unexpected), 64'(v.e_err));
        end

        // Full and wrap-around
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_in(1, 32'h40 + 32'(i), 0, 0, 0, 0);
            #1;
            chk("full alloc_tag", 64'(alloc_tag), 64'(i));
            chk("full alloc_ready", 64'(alloc_ready), 64'd1);
        end
        @(negedge clk);
        set_in(1, 32'h50, 0, 0, 0, 0);
        #1;
        chk("full ready_low", 64'(alloc_ready), 64'd0);
        chk("full count8", 64'(count), 64'd8);
        @(negedge clk);
        set_in(0, 0, 1, 0, 64'h123, 0);
        #1;
        chk("full no_out_yet", 64'(rout.valid), 64'd0);
        @(negedge clk);
        set_in(1, 32'h50, 0, 0, 0, 1);
        #1;
        chk("full head_id", 64'(rout.id), 64'h40);
        chk("full ready_during_retire", 64'(alloc_ready), 64'd0);
        @(negedge clk);
        set_in(1, 32'h50, 0, 0, 0, 1);
        #1;
        chk("wrap alloc_ready", 64'(alloc_ready), 64'd1);
        chk("wrap alloc_tag", 64'(alloc_tag), 64'd0);
        chk("wrap count7", 64'(count), 64'd7);
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 1);
        #1;
        chk("wrap full_again", 64'(alloc_ready), 64'd0);
        chk("wrap count8", 64'(count), 64'd8);

        // Backpressure holds payload
        do_reset();
        @(negedge clk);
        set_in(1, 32'h77, 0, 0, 0, 0);
        @(negedge clk);
        set_in(0, 0, 1, 0, 64'hCAFE, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            set_in(0, 0, 0, 0, 0, 0);
            #1;
            chk("bp valid", 64'(rout.valid), 64'd1);
            chk("bp data", rout.data, 64'hCAFE);
            chk("bp id", 64'(rout.id), 64'h77);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 1);
        #1;
        chk("bp retire_data", rout.data, 64'hCAFE);
        @(negedge clk);
        #1;
        chk("bp gone", 64'(rout.valid), 64'd0);
        chk("bp count", 64'(count), 64'd0);

        // Reset mid-flight
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_in(1, 32'h60 + 32'(i), 0, 0, 0, 0);
        end
        @(negedge clk);
        set_in(0, 0, 1, 0, 64'h5, 0);
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0);
        #1;
        chk("mid pre_valid", 64'(rout.valid), 64'd1);
        chk("mid pre_count", 64'(count), 64'd4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid rst_valid", 64'(rout.valid), 64'd0);
        chk("mid rst_data", rout.data, 64'd0);
        chk("mid rst_count", 64'(count), 64'd0);
        chk("mid rst_tag", 64'(alloc_tag), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        set_in(1, 32'h99, 0, 0, 0, 1);
        #1;
        chk("mid first_tag", 64'(alloc_tag), 64'd0);
        @(negedge clk);
        set_in(0, 0, 1, 1, 64'h1, 1);
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 1);
        #1;
        chk("mid stale_err", 64'(err_unexpected), 64'd1);
        chk("mid stale_valid", 64'(rout.valid), 64'd0);
        chk("mid stale_count", 64'(count), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/r_ordering_unit.md
R_ORDERING_UNIT -- requirements
Module: r_ordering_unit

Interface
REQ-001 Parameters SHALL be: ID_WIDTH, 32, AXI ID width; DATA_WIDTH, 64, R data width; RESP_WIDTH, 2, RRESP width; DEPTH, 8, reorder slots (power of 2, >=2).
REQ-002 TAG_W SHALL be $clog2(DEPTH).
REQ-003 Port list (name, direction, width, meaning) SHALL be:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- alloc_valid  input  1  AR path requests a slot.
- alloc_ready  output  1  slot available.
- alloc_orig_id  input  ID_WIDTH  master's original ARID.
- alloc_tag  output  TAG_W  tag assigned; AR path drives it as slave ARID.
- r_in  r_if.receiver  bundle  R beats from incoming_response_buffer; id[TAG_W-1:0] = tag.
- r_out  r_if.sender  bundle  R beats to master, in allocation order.
- count  output  $clog2(DEPTH+1)  slots not FREE.
- err_unexpected  output  1  one-cycle pulse: bad beat dropped.

Function
REQ-004 Each slot SHALL hold state (FREE, PENDING, FILLED), orig_id, data, resp, last.
REQ-005 Head pointer hd and tail pointer tl SHALL be TAG_W bits, wrapping DEPTH-1 -> 0.
REQ-006 alloc_ready SHALL be 1 iff slot[tl] is FREE; alloc_tag SHALL equal tl combinationally.
REQ-007 On alloc_valid & alloc_ready: slot[tl] <= PENDING, orig_id stored, tl increments.
REQ-008 r_in.ready SHALL be constant 1; every presented beat is accepted in that cycle.
REQ-009 Accepted beat with id[ID_WIDTH-1:TAG_W] == 0 and slot[id] PENDING: store data/resp/last, slot <= FILLED.
REQ-010 Any other accepted beat (upper id bits nonzero, target slot FREE or FILLED) SHALL be discarded, no state change, err_unexpected = 1 the next cycle.
REQ-011 r_out.valid SHALL be 1 iff slot[hd] is FILLED; r_out.id/data/resp/last SHALL be driven from slot[hd], zero when r_out.valid = 0.
REQ-012 r_out.id SHALL be orig_id zero-extended/truncated to ID_WIDTH.
REQ-013 On r_out.valid & r_out.ready: slot[hd] <= FREE, hd increments.
REQ-014 Latency: beat filling slot[hd] in cycle N SHALL appear on r_out in cycle N+1 (state-registered, no bypass).
REQ-015 r_out payload SHALL be held stable while r_out.valid & ~r_out.ready.
REQ-016 Allocate, fill and retire in one cycle SHALL all take effect; count = count + alloc - retire.
REQ-017 Full (count == DEPTH): alloc_ready = 0; a simultaneous retire frees the slot from the next cycle only.
REQ-018 A beat whose tag equals the slot being allocated in the same cycle SHALL be treated per REQ-010 (slot still FREE).
REQ-019 Responses are single-beat; last SHALL be stored and forwarded unchanged, not interpreted.
REQ-020 Control logic SHALL use only bitwise &, |, ~.

Reset
REQ-021 While rst = 1: all slots FREE, hd = tl = 0, count = 0, err_unexpected = 0, r_out.valid = 0, r_out payload 0, alloc_ready = 1, alloc_tag = 0.
REQ-022 Reset asserted mid-operation SHALL drop all pending and filled entries without emitting them; first post-reset allocation receives tag 0.

Verification
REQ-023 In-order: allocate orig_ids 0x11,0x22 (tags 0,1); beats tag0 then tag1; r_out.ready = 1 -> r_out ids 0x11,0x22 with matching data, each 1 cycle after fill.
REQ-024 Out-of-order: allocate 0xA,0xB,0xC; beats tag2 (data 3), tag0 (data 1), tag1 (data 2) -> r_out data 1,2,3 in that order; nothing emitted before tag0 arrives.
REQ-025 Full/wrap: allocate 8 -> alloc_ready = 0, count = 8; fill and retire tag0 -> next alloc gets tag 0, then alloc_ready = 0 again.
REQ-026 Backpressure: head FILLED, r_out.ready = 0 for 5 cycles -> r_out.valid = 1 and payload unchanged; retire on cycle 6.
REQ-027 Error: beat to FREE tag 3, repeat beat to FILLED tag 0, and beat with id 0x100 -> each discarded, err_unexpected one-cycle pulse, count unchanged.
REQ-028 Reset mid-flight: 3 PENDING and 1 FILLED, pulse rst -> r_out.valid = 0, count = 0, next alloc_tag = 0.
